vram_arbiter: RTL and testbench

Shares the single-port picture RAM between the VGA scan-out path and the Tetris game-logic writer. Display reads take absolute priority whenever the sync generator flags the active region. Writer requests are buffered in a small FIFO and committed only in cycles with no display read, typically during horizontal and vertical blanking. The block sits between the sync generator (`sync_ready_sig`/`pic_addr`), the board renderer and the RAM macro.

---
 rtl/vram_if.sv | 43 ++++
 rtl/vram_arbiter.sv | 158 +++++++++++++++
 tb/tb_vram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_if.sv
// Signal bundle between the picture-RAM arbiter and its neighbours:
// the sync generator (display reads), the board renderer (writes) and
// the single-port RAM macro. The arbiter uses the slave modport; the
// environment driving requests and modelling the RAM uses master.
//
// Handshake: a write transfers on every rising clk edge where
// wr_req && wr_ready are both 1; wr_ready does not depend on wr_req, and
// the writer must hold wr_addr/wr_data stable while wr_req is high and
// wr_ready is low. Display reads have no back-pressure: disp_req is
// always honoured and answered by disp_valid two edges later.
interface vram_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 8
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              wr_oob;
   logic              busy;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
      output disp_data, disp_valid, wr_ready, wr_oob, busy,
             mem_addr, mem_we, mem_wdata
   );

   modport master (
      output disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
      input  disp_data, disp_valid, wr_ready, wr_oob, busy,
             mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Picture-RAM arbiter: display reads always win the RAM port; game-logic
// writes wait in a small FIFO and are committed in cycles without a read
// (blanking). RAM address/write controls are registered; read data comes
// back one cycle after the address and is re-registered, so disp_valid is
// disp_req delayed by two edges.
module vram_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PIX_COUNT  = 307200
) (
   input  logic       clk,
   input  logic       rst,
   vram_if.slave      bus,
   output logic [1:0] dbg_grant
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(PIX_COUNT);

   // Port owner for the current edge; the registered copy is the
   // observable arbiter state.
   typedef enum logic [1:0] {
      GNT_IDLE  = 2'd0,
      GNT_DISP  = 2'd1,
      GNT_WRITE = 2'd2
   } grant_e;

   grant_e grant_q, grant_d;

   // Writer FIFO
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full, empty;
   logic              accept, in_range, push, pop;

   // RAM port and display pipeline registers
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_we_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              rd_tag1, rd_tag2;
   logic              disp_valid_q;
   logic [DATA_W-1:0] disp_data_q;
   logic              wr_oob_q;

   // Readiness comes only from the registered count, so a pop in the same
   // cycle never lets a push into a full FIFO.
   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign accept   = bus.wr_req && !full;
   assign in_range = (bus.wr_addr < PIX_LIMIT);
   assign push     = accept && in_range;

   // Arbitration: display first, then FIFO head, else idle.
   always_comb begin
      grant_d = GNT_IDLE;
      pop     = 1'b0;
      if (bus.disp_req) begin
         grant_d = GNT_DISP;
      end else if (!empty) begin
         grant_d = GNT_WRITE;
         pop     = 1'b1;
      end
   end

   // Arbiter state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) grant_q <= GNT_IDLE;
      else     grant_q <= grant_d;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; contents are meaningless while the count says empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.wr_addr;
         fifo_data[wr_ptr] <= bus.wr_data;
      end
   end

   // RAM port registers; write enable is cleared asynchronously so a
   // reset can never leave a half-issued write on the RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         case (grant_d)
            GNT_DISP: begin
               mem_addr_q <= bus.disp_addr;
               mem_we_q   <= 1'b0;
            end
            GNT_WRITE: begin
               mem_addr_q  <= fifo_addr[rd_ptr];
               mem_wdata_q <= fifo_data[rd_ptr];
               mem_we_q    <= 1'b1;
            end
            default: begin
               mem_we_q <= 1'b0;
            end
         endcase
      end
   end

   // Read tag pipeline: tag1 follows the address cycle, tag2 the RAM data
   // cycle, and the output stage captures the RAM data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_tag1      <= 1'b0;
         rd_tag2      <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_data_q  <= '0;
      end else begin
         rd_tag1      <= bus.disp_req;
         rd_tag2      <= rd_tag1;
         disp_valid_q <= rd_tag2;
         if (rd_tag2) disp_data_q <= bus.mem_rdata;
      end
   end

   // Out-of-range flag: one-cycle pulse after an accepted bad write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_oob_q <= 1'b0;
      else     wr_oob_q <= accept && !in_range;
   end

   assign bus.wr_ready   = !full;
   assign bus.wr_oob     = wr_oob_q;
   assign bus.busy       = !empty || mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.disp_valid = disp_valid_q;
   assign bus.disp_data  = disp_data_q;
   assign dbg_grant      = grant_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, queue-based reference model checked
// every cycle, a vector table, hand-written corner sequences and random
// traffic.
module tb_vram_arbiter;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int PIX    = 307200;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_grant;

   vram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
                  .PIX_COUNT(PIX)) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_grant(dbg_grant));

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Synchronous single-port RAM, read-before-write, one-cycle read latency.
   logic [7:0] ram [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   // scoreboard counters
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending writes as a queue, memory as an array, and
   // the read stream as a history of (request, data) per edge.
   typedef struct { logic [ADDR_W-1:0] a; logic [7:0] d; } wr_t;
   typedef struct { bit v; logic [7:0] d; } rd_t;
   wr_t               pend_q[$];
   rd_t               hist_q[$];
   logic [7:0]        ref_mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] exp_q[$];
   bit                exp_we, exp_oob, exp_valid;
   logic [ADDR_W-1:0] exp_maddr;
   logic [7:0]        exp_mwdata, exp_ddata;

   int we_cnt = 0, oob_cnt = 0, we_in_disp = 0;
   bit disp_prev;

   task automatic model_reset();
      pend_q.delete();
      hist_q.delete();
      exp_we = 0; exp_oob = 0; exp_valid = 0;
      exp_maddr = '0; exp_mwdata = '0; exp_ddata = '0;
   endtask

   task automatic model_step();
      bit  acc;
      rd_t r, e;
      wr_t w;
      acc = bus.wr_req && (pend_q.size() < DEPTH);
      r.v = bus.disp_req;
      r.d = bus.disp_req ? ref_mem[bus.disp_addr] : 8'h00;
      if (bus.disp_req) begin
         exp_we = 0;
         exp_maddr = bus.disp_addr;
      end else if (pend_q.size() > 0) begin
         w = pend_q.pop_front();
         ref_mem[w.a] = w.d;
         exp_we = 1; exp_maddr = w.a; exp_mwdata = w.d;
      end else begin
         exp_we = 0;
      end
      exp_oob = acc && (int'(bus.wr_addr) >= PIX);
      if (acc && int'(bus.wr_addr) < PIX) begin
         w.a = bus.wr_addr; w.d = bus.wr_data;
         pend_q.push_back(w);
      end
      hist_q.push_back(r);
      exp_valid = 0;
      if (hist_q.size() > 2) begin
         e = hist_q.pop_front();
         exp_valid = e.v;
         if (e.v) exp_ddata = e.d;
      end
   endtask

   task automatic check_model();
      chk("m_disp_valid", 32'(bus.disp_valid), 32'(exp_valid));
      if (exp_valid) chk("m_disp_data", 32'(bus.disp_data), 32'(exp_ddata));
      chk("m_mem_we", 32'(bus.mem_we), 32'(exp_we));
      chk("m_mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
      if (exp_we) chk("m_mem_wdata", 32'(bus.mem_wdata), 32'(exp_mwdata));
      chk("m_wr_ready", 32'(bus.wr_ready), 32'(pend_q.size() < DEPTH));
      chk("m_wr_oob", 32'(bus.wr_oob), 32'(exp_oob));
      chk("m_busy", 32'(bus.busy), 32'((pend_q.size() > 0) || exp_we));
   endtask

   // One clock: model and DUT advance on the same edge, compare 1 ns later.
   task automatic tick();
      disp_prev = bus.disp_req;
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      check_model();
      if (bus.mem_we) begin
         we_cnt++;
         if (disp_prev) we_in_disp++;
      end
      if (bus.wr_oob) oob_cnt++;
   endtask

   // driver tasks
   task automatic drive(input bit d, input int da, input bit w, input int wa, input int wd);
      bus.disp_req  = d;
      bus.disp_addr = ADDR_W'(da);
      bus.wr_req    = w;
      bus.wr_addr   = ADDR_W'(wa);
      bus.wr_data   = 8'(wd);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      drive(0, 0, 0, 0, 0);
      while (n < 40) begin
         tick();
         if (!bus.busy) break;
         n++;
      end
      chk({name, "_drain_timeout"}, 32'(n < 40), 32'd1);
   endtask

   // vector table
   typedef struct {
      bit d; int da; bit w; int wa; int wd;
      bit e_we; int e_maddr; bit e_rdy; bit e_oob; bit e_busy; bit e_v; int e_dd;
   } vec_t;
   vec_t vecs[15];

   function automatic vec_t mk(bit d, int da, bit w, int wa, int wd, bit ewe, int ema,
                               bit erdy, bit eoob, bit ebusy, bit ev, int edd);
      vec_t v;
      v.d = d; v.da = da; v.w = w; v.wa = wa; v.wd = wd;
      v.e_we = ewe; v.e_maddr = ema; v.e_rdy = erdy; v.e_oob = eoob;
      v.e_busy = ebusy; v.e_v = ev; v.e_dd = edd;
      return v;
   endfunction

   initial begin
      int first_valid, vcount, k, t, oob0, we0, wd;
      int rlen;
      bit rd;

      for (int i = 0; i < (1 << ADDR_W); i++) begin
         ram[i]     = 8'(i);
         ref_mem[i] = 8'(i);
      end
      drive(0, 0, 0, 0, 0);
      model_reset();

      // reset state
      rst = 1'b1;
      tick();
      tick();
      chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
      chk("rst_disp_data", 32'(bus.disp_data), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
      chk("rst_wr_oob", 32'(bus.wr_oob), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;

      // read stream 0..639
      first_valid = -1; vcount = 0; k = 0; t = 0;
      for (int i = 0; i < 643; i++) begin
         if (i < 640) drive(1, i, 0, 0, 0);
         else         drive(0, 0, 0, 0, 0);
         tick();
         if (bus.disp_valid) begin
            if (first_valid < 0) first_valid = t;
            exp_q.push_back(8'(k));
            chk("stream_data", 32'(bus.disp_data), 32'(exp_q.pop_front()));
            k++;
            vcount++;
         end
         t++;
      end
      chk("stream_first", 32'(first_valid), 32'd2);
      chk("stream_count", 32'(vcount), 32'd640);

      // vector table
      vecs[0]  = mk(0, 0,  1, 10, 'h11,     0, 639, 1, 0, 1, 0, 0);
      vecs[1]  = mk(0, 0,  1, 20, 'h22,     1, 10,  1, 0, 1, 0, 0);
      vecs[2]  = mk(1, 10, 0, 0,  0,        0, 10,  1, 0, 1, 0, 0);
      vecs[3]  = mk(0, 0,  1, PIX, 'h33,    1, 20,  1, 1, 1, 0, 0);
      vecs[4]  = mk(0, 0,  0, 0,  0,        0, 20,  1, 0, 0, 1, 'h11);
      vecs[5]  = mk(1, 20, 1, 1,  'h01,     0, 20,  1, 0, 1, 0, 0);
      vecs[6]  = mk(1, 5,  1, 2,  'h02,     0, 5,   1, 0, 1, 0, 0);
      vecs[7]  = mk(1, 6,  1, 3,  'h03,     0, 6,   1, 0, 1, 1, 'h22);
      vecs[8]  = mk(1, 7,  1, 4,  'h04,     0, 7,   0, 0, 1, 1, 'h05);
      vecs[9]  = mk(1, 8,  1, 9,  'h09,     0, 8,   0, 0, 1, 1, 'h06);
      vecs[10] = mk(0, 0,  1, 9,  'h09,     1, 1,   1, 0, 1, 1, 'h07);
      vecs[11] = mk(0, 0,  0, 0,  0,        1, 2,   1, 0, 1, 1, 'h08);
      vecs[12] = mk(0, 0,  0, 0,  0,        1, 3,   1, 0, 1, 0, 0);
      vecs[13] = mk(0, 0,  0, 0,  0,        1, 4,   1, 0, 1, 0, 0);
      vecs[14] = mk(0, 0,  0, 0,  0,        0, 4,   1, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].d, vecs[i].da, vecs[i].w, vecs[i].wa, vecs[i].wd);
         tick();
         chk($sformatf("vec%0d_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
         chk($sformatf("vec%0d_maddr", i), 32'(bus.mem_addr), 32'(vecs[i].e_maddr));
         chk($sformatf("vec%0d_ready", i), 32'(bus.wr_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("vec%0d_oob", i), 32'(bus.wr_oob), 32'(vecs[i].e_oob));
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
         chk($sformatf("vec%0d_valid", i), 32'(bus.disp_valid), 32'(vecs[i].e_v));
         if (vecs[i].e_v) chk($sformatf("vec%0d_data", i), 32'(bus.disp_data), 32'(vecs[i].e_dd));
      end

      // reset mid-operation with queued writes
      drive(1, 50, 1, 200, 'hEE); tick();
      drive(1, 51, 1, 201, 'hEF); tick();
      drive(1, 52, 1, 202, 'hF0); tick();
      drive(0, 0, 0, 0, 0);       tick();
      chk("mrst_pre_we", 32'(bus.mem_we), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("mrst_we_async", 32'(bus.mem_we), 32'd0);
      chk("mrst_ready", 32'(bus.wr_ready), 32'd1);
      chk("mrst_busy", 32'(bus.busy), 32'd0);
      tick();
      rst = 1'b0;
      we0 = we_cnt;
      tick();
      chk("mrst_valid1", 32'(bus.disp_valid), 32'd0);
      tick();
      chk("mrst_valid2", 32'(bus.disp_valid), 32'd0);
      tick(); tick();
      chk("mrst_no_we", 32'(we_cnt - we0), 32'd0);
      chk("mrst_ram200", 32'(ram[200]), 32'hC8);
      chk("mrst_ram201", 32'(ram[201]), 32'hC9);
      chk("mrst_ram202", 32'(ram[202]), 32'hCA);

      // wrap-around: 10 writes through the 4-entry FIFO
      oob0 = oob_cnt;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 1, 100 + i, 'hA0 + i);
         tick();
      end
      drain("wrap");
      for (int i = 0; i < 10; i++)
         chk($sformatf("wrap_ram%0d", 100 + i), 32'(ram[100 + i]), 32'(8'hA0 + 8'(i)));
      chk("wrap_no_oob", 32'(oob_cnt - oob0), 32'd0);

      // out of range, then last valid address
      oob0 = oob_cnt; we0 = we_cnt;
      drive(0, 0, 1, PIX, 'h11);     tick();
      drive(0, 0, 1, PIX - 1, 'h5A); tick();
      drain("oob");
      chk("oob_pulses", 32'(oob_cnt - oob0), 32'd1);
      chk("oob_we_count", 32'(we_cnt - we0), 32'd1);
      chk("oob_ram_last", 32'(ram[PIX - 1]), 32'h5A);

      // contention: disp_req toggles with two writes queued
      drive(1, 600, 1, 300, 'h31); tick();
      drive(1, 601, 1, 301, 'h32); tick();
      we0 = we_cnt; k = we_in_disp;
      for (int i = 0; i < 8; i++) begin
         drive(i % 2 == 1, 602 + i, 0, 0, 0);
         tick();
      end
      drain("cont");
      chk("cont_we_in_disp", 32'(we_in_disp - k), 32'd0);
      chk("cont_we_count", 32'(we_cnt - we0), 32'd2);
      chk("cont_ram300", 32'(ram[300]), 32'h31);
      chk("cont_ram301", 32'(ram[301]), 32'h32);

      // random traffic against the model
      rd = 0; rlen = 0;
      for (int i = 0; i < 2000; i++) begin
         if (rlen == 0) begin
            rd = !rd;
            rlen = rd ? $urandom_range(1, 24) : $urandom_range(1, 10);
         end
         rlen--;
         if ($urandom_range(0, 15) == 0) wd = PIX + $urandom_range(0, 1000);
         else                            wd = $urandom_range(0, 2047);
         drive(rd, $urandom_range(0, 2047), $urandom_range(0, 9) < 6, wd,
               $urandom_range(0, 255));
         tick();
      end
      drain("rand");
      chk("rand_no_we_in_disp", 32'(we_in_disp), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
